// File: rtl/fib_seq_gen.sv
// Generalised-Fibonacci term generator with per-run seeds/length, overflow tracking and a valid/ready output.
// Build option: define FIB_SAT_EN to clamp overflowed terms to all-ones instead of wrapping.
module fib_seq_gen #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             clr,
   input  logic [WIDTH-1:0] seed_a,
   input  logic [WIDTH-1:0] seed_b,
   input  logic [CNT_W-1:0] n_terms,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] out_idx,
   output logic             busy,
   output logic             done,
   output logic             ovf
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a, b;
   logic             a_mk, b_mk;
   logic [CNT_W-1:0] idx, n_len;
   logic [WIDTH:0]   sum;
   logic             sum_mk;
   logic [WIDTH-1:0] sum_term;
   logic             go, fire, last;

   assign go   = (state == S_IDLE) && start && !clr;
   assign fire = (state == S_RUN) && out_ready;
   assign last = (idx == n_len - CNT_W'(1));

   // A term is marked once its true value reaches 2^WIDTH; marks propagate since terms only grow.
   assign sum    = {1'b0, a} + {1'b0, b};
   assign sum_mk = sum[WIDTH] | a_mk | b_mk;
`ifdef FIB_SAT_EN
   assign sum_term = sum_mk ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
   assign sum_term = sum[WIDTH-1:0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (go) state_nxt = (n_terms != '0) ? S_RUN : S_DONE;
         S_RUN:   if (fire && last) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (clr) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a     <= '0;
         b     <= '0;
         a_mk  <= 1'b0;
         b_mk  <= 1'b0;
         idx   <= '0;
         n_len <= '0;
         ovf   <= 1'b0;
      end else if (go) begin
         a     <= seed_a;
         b     <= seed_b;
         a_mk  <= 1'b0;
         b_mk  <= 1'b0;
         idx   <= '0;
         n_len <= n_terms;
         ovf   <= 1'b0;
      end else if (fire && !last && !clr) begin
         a    <= b;
         a_mk <= b_mk;
         b    <= sum_term;
         b_mk <= sum_mk;
         idx  <= idx + CNT_W'(1);
         // ovf rises together with the first marked term reaching out_data
         if (b_mk) ovf <= 1'b1;
      end
   end

   assign out_valid = (state == S_RUN);
   assign out_data  = out_valid ? a : '0;
   assign out_idx   = out_valid ? idx : '0;
   assign busy      = (state == S_RUN);
   assign done      = (state == S_DONE);

endmodule
